// File: rtl/fetch_pkg_r32i.sv
// Shared types for the r32i fetch stage: NOP encoding, FSM states, buffer entry.
package fetch_pkg_r32i;

  localparam int unsigned DataW = 32;
  localparam logic [DataW-1:0] Nop = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fetchState_t;

  typedef struct packed {
    logic [DataW-1:0] addr;
    logic [DataW-1:0] instr;
    logic             misalign;
  } fetchEntry_t;

endpackage

// File: rtl/fetch_fifo_r32i.sv
// Instruction buffer with registered head, flush and occupancy count.
module fetch_fifo_r32i
  import fetch_pkg_r32i::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      push,
  input  fetchEntry_t               pushData,
  input  logic                      pop,
  output fetchEntry_t               headData,
  output logic [$clog2(Depth):0]    count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  fetchEntry_t     mem [Depth];
  logic [PtrW-1:0] rdPtr;
  logic [PtrW-1:0] wrPtr;
  logic [PtrW-1:0] rdPtrNext;
  logic [CntW-1:0] countNext;
  logic            doPush;
  logic            doPop;

  assign doPop     = pop && (count != '0);
  assign doPush    = push && ((count != CntW'(Depth)) || doPop);
  assign rdPtrNext = doPop ? rdPtr + PtrW'(1) : rdPtr;

  always_comb begin
    countNext = count;
    if (doPush && !doPop)      countNext = count + CntW'(1);
    else if (doPop && !doPush) countNext = count - CntW'(1);
  end

  // Head register: a freshly pushed entry bypasses storage when it becomes the head.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
      headData <= '0;
    end else if (flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PtrW'(1);
      rdPtr <= rdPtrNext;
      count <= countNext;
      if (countNext != '0)
        headData <= (doPush && (rdPtrNext == wrPtr)) ? pushData : mem[rdPtrNext];
    end
  end

  always_ff @(posedge clock) begin
    if (doPush && !flush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/fetch_unit_r32i.sv
// r32i fetch stage: issues word reads for ProgAddr, buffers responses for decode.
// FETCH_MISALIGN_TRAP_EN turns misaligned PCs into flagged NOP entries.
module fetch_unit_r32i
  import fetch_pkg_r32i::*;
#(
  parameter int unsigned dataW     = 32,
  parameter int unsigned FifoDepth = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [dataW-1:0] ProgAddr,
  output logic             PCAdvance,
  input  logic             Flush,
  output logic             MemReq,
  output logic [dataW-1:0] MemAddr,
  input  logic             MemGnt,
  input  logic             MemRValid,
  input  logic [dataW-1:0] MemRData,
  output logic             InstrValid,
  output logic [dataW-1:0] Instr,
  output logic [dataW-1:0] InstrAddr,
  input  logic             InstrReady,
  output logic             InstrMisalign
);

  localparam int unsigned CntW = $clog2(FifoDepth) + 1;

  fetchState_t      state;
  fetchState_t      stateNext;
  logic             outstanding;
  logic             outstandingNext;
  logic [dataW-1:0] reqAddr;
  logic [dataW-1:0] alignedAddr;
  logic [CntW-1:0]  count;
  logic             room;
  logic             misalignPC;
  logic             push;
  logic             pop;
  fetchEntry_t      pushData;
  fetchEntry_t      head;

  assign alignedAddr = {ProgAddr[dataW-1:2], 2'b00};
  // A request is only issued when its response is guaranteed a buffer slot.
  assign room        = (count + CntW'(outstanding)) < CntW'(FifoDepth);
  assign pop         = InstrValid && InstrReady;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalignPC    = (ProgAddr[1:0] != 2'b00);
  assign InstrMisalign = head.misalign;
`else
  logic unusedMisalign;
  assign misalignPC     = 1'b0;
  assign InstrMisalign  = 1'b0;
  assign unusedMisalign = head.misalign;
`endif

  always_comb begin
    stateNext       = state;
    outstandingNext = outstanding;
    MemReq          = 1'b0;
    MemAddr         = '0;
    PCAdvance       = 1'b0;
    push            = 1'b0;
    pushData        = '0;
    case (state)
      IDLE: stateNext = REQ;
      REQ: begin
        if (room) begin
          if (misalignPC) begin
            push      = !Flush;
            PCAdvance = !Flush;
            pushData  = '{addr: ProgAddr, instr: Nop, misalign: 1'b1};
          end else begin
            MemReq  = 1'b1;
            MemAddr = alignedAddr;
            if (MemGnt) begin
              outstandingNext = 1'b1;
              PCAdvance       = !Flush;
              stateNext       = Flush ? DRAIN : WAIT;
            end
          end
        end
      end
      WAIT: begin
        if (MemRValid) begin
          push            = !Flush;
          pushData        = '{addr: reqAddr, instr: MemRData, misalign: 1'b0};
          outstandingNext = 1'b0;
          stateNext       = REQ;
        end else if (Flush) begin
          stateNext = DRAIN;
        end
      end
      DRAIN: begin
        if (MemRValid) begin
          outstandingNext = 1'b0;
          stateNext       = REQ;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      outstanding <= 1'b0;
      reqAddr     <= '0;
    end else begin
      state       <= stateNext;
      outstanding <= outstandingNext;
      if (MemReq && MemGnt) reqAddr <= alignedAddr;
    end
  end

  fetch_fifo_r32i #(
    .Depth(FifoDepth)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .flush   (Flush),
    .push    (push),
    .pushData(pushData),
    .pop     (pop),
    .headData(head),
    .count   (count)
  );

  assign InstrValid = (count != '0);
  assign Instr      = head.instr;
  assign InstrAddr  = head.addr;

endmodule

// File: tb/tb_fetch_unit_r32i.sv
// Bench for fetch_unit_r32i: directed phases plus a randomized phase checked
// against a transaction-level model of the expected instruction stream.
module tb_fetch_unit_r32i;

  localparam int DEPTH = 2;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit MisalignMode = 1'b1;
`else
  localparam bit MisalignMode = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] ProgAddr;
  logic        PCAdvance;
  logic        Flush;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemGnt;
  logic        MemRValid;
  logic [31:0] MemRData;
  logic        InstrValid;
  logic [31:0] Instr;
  logic [31:0] InstrAddr;
  logic        InstrReady;
  logic        InstrMisalign;

  always #5 clock = ~clock;

  fetch_unit_r32i #(.dataW(32), .FifoDepth(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .ProgAddr     (ProgAddr),
    .PCAdvance    (PCAdvance),
    .Flush        (Flush),
    .MemReq       (MemReq),
    .MemAddr      (MemAddr),
    .MemGnt       (MemGnt),
    .MemRValid    (MemRValid),
    .MemRData     (MemRData),
    .InstrValid   (InstrValid),
    .Instr        (Instr),
    .InstrAddr    (InstrAddr),
    .InstrReady   (InstrReady),
    .InstrMisalign(InstrMisalign)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        mis;
  } expEntry_t;

  expEntry_t   expQ[$];
  logic [31:0] popAddrs[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] pc = 32'h0;
  logic [31:0] reqAddr = 32'h0;
  logic [31:0] respAddr = 32'h0;
  logic [31:0] flushTarget = 32'h0;
  int          respCd = 0;
  int          latMin = 1;
  int          latMax = 1;
  int          gntPct = 100;
  int          readyPct = 100;
  bit          inflight = 1'b0;
  bit          inflightGood = 1'b0;
  bit          flushOnRvalid = 1'b0;
  bit          flushOnGrant = 1'b0;
  bit          randFlush = 1'b0;
  int          idx;
  int          n;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Rule checks on the current cycle, then advance the model across the edge.
  task automatic checkAndModel();
    bit gnt;
    bit misPc;
    if (!reset) begin
      expQ.delete();
      inflight     = 1'b0;
      inflightGood = 1'b0;
      return;
    end
    gnt   = MemReq && MemGnt;
    misPc = MisalignMode && (pc[1:0] != 2'b00);
    chk("instr_valid", 32'(InstrValid), 32'(expQ.size() != 0));
    if (InstrValid && expQ.size() != 0) begin
      chk("instr_data", Instr, expQ[0].instr);
      chk("instr_addr", InstrAddr, expQ[0].addr);
      chk("instr_misalign", 32'(InstrMisalign), 32'(expQ[0].mis));
    end
    if (MemReq) begin
      chk("mem_addr", MemAddr, pc & ~32'h3);
      chk("no_overissue", 32'((expQ.size() + int'(inflight)) < DEPTH), 32'd1);
    end
    if (misPc) begin
      chk("mis_no_req", 32'(MemReq), 32'd0);
      if (PCAdvance) chk("mis_room", 32'(expQ.size() < DEPTH), 32'd1);
    end else begin
      chk("pc_advance", 32'(PCAdvance), 32'(gnt && !Flush));
    end

    if (InstrValid && InstrReady && !Flush && expQ.size() != 0) begin
      popAddrs.push_back(InstrAddr);
      void'(expQ.pop_front());
    end
    if (MemRValid && inflight) begin
      if (inflightGood && !Flush)
        expQ.push_back('{addr: reqAddr, instr: memWord(reqAddr), mis: 1'b0});
      inflight = 1'b0;
    end
    if (gnt) begin
      inflight     = 1'b1;
      inflightGood = 1'b1;
      reqAddr      = pc & ~32'h3;
      respAddr     = MemAddr;
      respCd       = int'($urandom_range(latMax, latMin));
    end
    if (misPc && PCAdvance && !Flush)
      expQ.push_back('{addr: pc, instr: 32'h0000_0013, mis: 1'b1});
    if (Flush) begin
      expQ.delete();
      inflightGood = 1'b0;
      pc = flushTarget;
    end else if (PCAdvance) begin
      pc = pc + 32'd4;
    end
  endtask

  task automatic drive();
    bit wasRvalid;
    wasRvalid = MemRValid;
    MemRValid = 1'b0;
    if (respCd > 0) begin
      respCd--;
      if (respCd == 0) begin
        MemRValid = 1'b1;
        MemRData  = memWord(respAddr);
      end
    end
    ProgAddr = pc;
    Flush    = 1'b0;
    if (flushOnRvalid && MemRValid) begin
      Flush = 1'b1; flushTarget = pc; flushOnRvalid = 1'b0;
    end
    if (flushOnGrant && wasRvalid) begin
      Flush = 1'b1; flushTarget = pc; flushOnGrant = 1'b0;
    end
    if (randFlush && $urandom_range(99) < 4) begin
      Flush = 1'b1; flushTarget = $urandom & 32'h0000_0ffc;
    end
    InstrReady = ($urandom_range(99) < readyPct);
    MemGnt     = ($urandom_range(99) < gntPct);
  endtask

  // Entered and left at a falling edge.
  task automatic step();
    #1;
    checkAndModel();
    @(posedge clock);
    #1;
    drive();
    @(negedge clock);
  endtask

  task automatic waitGrant(input string tag);
    int k;
    k = 0;
    while (!(MemReq && MemGnt) && k < 30) begin
      step();
      k++;
    end
    chk(tag, 32'(MemReq && MemGnt), 32'd1);
  endtask

  task automatic raiseFlush(input logic [31:0] target);
    Flush       = 1'b1;
    flushTarget = target;
    step();
  endtask

  initial begin
    reset = 1'b0; ProgAddr = '0; Flush = 1'b0; MemGnt = 1'b0;
    MemRValid = 1'b0; MemRData = '0; InstrReady = 1'b0;
    @(negedge clock);
    chk("rst_memreq", 32'(MemReq), 32'd0);
    chk("rst_memaddr", MemAddr, 32'd0);
    chk("rst_pcadv", 32'(PCAdvance), 32'd0);
    chk("rst_valid", 32'(InstrValid), 32'd0);
    chk("rst_instr", Instr, 32'd0);
    chk("rst_instraddr", InstrAddr, 32'd0);
    chk("rst_misalign", 32'(InstrMisalign), 32'd0);
    step(); step();
    reset = 1'b1;

    // Straight-line stream from address 0, 1-cycle latency.
    repeat (14) step();
    chk("stream_len", 32'(popAddrs.size() >= 3), 32'd1);
    if (popAddrs.size() >= 3) begin
      chk("stream0", popAddrs[0], 32'h0);
      chk("stream1", popAddrs[1], 32'h4);
      chk("stream2", popAddrs[2], 32'h8);
    end

    // Backpressure: buffer fills to depth and requests stop.
    readyPct = 0;
    repeat (6) step();
    chk("bp_valid", 32'(InstrValid), 32'd1);
    chk("bp_memreq", 32'(MemReq), 32'd0);
    chk("bp_pcadv", 32'(PCAdvance), 32'd0);
    readyPct = 100;
    repeat (10) step();

    // Flush while waiting on a 3-cycle response, redirect to 64.
    latMin = 3; latMax = 3;
    waitGrant("grant_lat3");
    step();
    raiseFlush(32'd64);
    chk("flush_wait_empty", 32'(InstrValid), 32'd0);
    idx = popAddrs.size();
    repeat (20) step();
    if (popAddrs.size() > idx) chk("redirect_addr", popAddrs[idx], 32'd64);
    else chk("redirect_pops", 32'(popAddrs.size()), 32'(idx + 1));

    // Flush coincident with the response.
    latMin = 1; latMax = 1;
    flushOnRvalid = 1'b1;
    n = 0;
    while (flushOnRvalid && n < 20) begin step(); n++; end
    chk("flush_rv_armed", 32'(flushOnRvalid), 32'd0);
    step();
    chk("flush_rv_empty", 32'(InstrValid), 32'd0);
    repeat (4) step();

    // Flush coincident with a grant.
    flushOnGrant = 1'b1;
    n = 0;
    while (flushOnGrant && n < 20) begin step(); n++; end
    chk("flush_gnt_armed", 32'(flushOnGrant), 32'd0);
    chk("flush_gnt_req", 32'(MemReq), 32'd1);
    chk("flush_gnt_pcadv", 32'(PCAdvance), 32'd0);
    step();
    chk("flush_gnt_empty", 32'(InstrValid), 32'd0);
    repeat (8) step();

    // Reset in the middle of a wait; the late response must be ignored.
    latMin = 3; latMax = 3;
    waitGrant("grant_before_rst");
    step();
    reset = 1'b0;
    #1;
    chk("midrst_memreq", 32'(MemReq), 32'd0);
    chk("midrst_memaddr", MemAddr, 32'd0);
    chk("midrst_pcadv", 32'(PCAdvance), 32'd0);
    chk("midrst_valid", 32'(InstrValid), 32'd0);
    chk("midrst_instr", Instr, 32'd0);
    chk("midrst_instraddr", InstrAddr, 32'd0);
    gntPct = 0;
    step();
    reset = 1'b1;
    repeat (6) step();
    chk("late_ignored_valid", 32'(InstrValid), 32'd0);
    chk("late_ignored_req", 32'(MemReq), 32'd1);
    gntPct = 100;
    repeat (10) step();

    // Randomized traffic.
    latMin = 1; latMax = 3; gntPct = 70; readyPct = 60; randFlush = 1'b1;
    repeat (400) step();
    randFlush = 1'b0; gntPct = 100; readyPct = 100; latMin = 1; latMax = 1;
    repeat (12) step();

    // Misaligned PC.
    raiseFlush(32'h66);
`ifdef FETCH_MISALIGN_TRAP_EN
    n = 0;
    while (!InstrValid && n < 20) begin step(); n++; end
    chk("mis_valid", 32'(InstrValid), 32'd1);
    chk("mis_instr", Instr, 32'h0000_0013);
    chk("mis_flag", 32'(InstrMisalign), 32'd1);
    chk("mis_addr", InstrAddr, 32'h66);
`else
    waitGrant("mis_grant");
    chk("mis_memaddr", MemAddr, 32'h64);
`endif
    repeat (6) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
